// File: rtl/vector_conversion_sequencer_if.sv
// ---------------------------------------------------------------------------
// vector_conversion_sequencer_if
//
// Purpose:
//   Bundles every non-clock/reset signal of the vector conversion sequencer:
//   the issue-side request handshake, the vector register file read and
//   write ports, the conversion unit operand/result pair and the completion
//   pulse.
//
// Modports:
//   slave  - the sequencer itself (takes requests, drives the RF and CU ports)
//   master - the surrounding environment (issue, register file, conversion unit)
//
// Signal summary:
//   request_valid / request_ready      instruction handshake
//   request_conversion_mode            conversion mode
//   request_sign_mode                  1 = signed
//   request_widening                   1 = mode produces vd and vd_high
//   request_word_count                 number of source words to process
//   request_vs2_base / request_vd_base source / destination register
//   rf_read_enable / rf_read_address   register file read port
//   rf_read_data                       read data, valid one cycle after the strobe
//   cu_conversion_mode / cu_sign_mode  registered controls to the conversion unit
//   cu_vs2                             operand register to the conversion unit
//   cu_vd / cu_vd_high                 conversion unit results (combinational)
//   rf_write_enable / rf_write_address / rf_write_data  register file write port
//   done                               one-cycle completion pulse
//   busy_cycles                        only with CONVERSION_SEQUENCER_PERF_COUNTER_EN
// ---------------------------------------------------------------------------
interface vector_conversion_sequencer_if #(
    parameter int WORD_INDEX_WIDTH      = 3,
    parameter int REGISTER_INDEX_WIDTH  = 5,
    parameter int CONVERSION_MODE_WIDTH = 4
);
    localparam int AW = REGISTER_INDEX_WIDTH + WORD_INDEX_WIDTH;

    logic                             request_valid;
    logic                             request_ready;
    logic [CONVERSION_MODE_WIDTH-1:0] request_conversion_mode;
    logic                             request_sign_mode;
    logic                             request_widening;
    logic [WORD_INDEX_WIDTH:0]        request_word_count;
    logic [REGISTER_INDEX_WIDTH-1:0]  request_vs2_base;
    logic [REGISTER_INDEX_WIDTH-1:0]  request_vd_base;

    logic                             rf_read_enable;
    logic [AW-1:0]                    rf_read_address;
    logic [63:0]                      rf_read_data;

    logic [CONVERSION_MODE_WIDTH-1:0] cu_conversion_mode;
    logic                             cu_sign_mode;
    logic [63:0]                      cu_vs2;
    logic [63:0]                      cu_vd;
    logic [63:0]                      cu_vd_high;

    logic                             rf_write_enable;
    logic [AW-1:0]                    rf_write_address;
    logic [63:0]                      rf_write_data;

    logic                             done;

`ifdef CONVERSION_SEQUENCER_PERF_COUNTER_EN
    logic [31:0]                      busy_cycles;
`endif

    // The sequencer's view of the bundle.
    modport slave (
`ifdef CONVERSION_SEQUENCER_PERF_COUNTER_EN
        output busy_cycles,
`endif
        input  request_valid, request_conversion_mode, request_sign_mode,
        input  request_widening, request_word_count, request_vs2_base, request_vd_base,
        output request_ready,
        output rf_read_enable, rf_read_address,
        input  rf_read_data,
        output cu_conversion_mode, cu_sign_mode, cu_vs2,
        input  cu_vd, cu_vd_high,
        output rf_write_enable, rf_write_address, rf_write_data,
        output done
    );

    // The environment's view: issue, register file and conversion unit.
    modport master (
`ifdef CONVERSION_SEQUENCER_PERF_COUNTER_EN
        input  busy_cycles,
`endif
        output request_valid, request_conversion_mode, request_sign_mode,
        output request_widening, request_word_count, request_vs2_base, request_vd_base,
        input  request_ready,
        input  rf_read_enable, rf_read_address,
        output rf_read_data,
        input  cu_conversion_mode, cu_sign_mode, cu_vs2,
        output cu_vd, cu_vd_high,
        input  rf_write_enable, rf_write_address, rf_write_data,
        input  done
    );
endinterface

// File: rtl/vector_conversion_sequencer.sv
// ---------------------------------------------------------------------------
// vector_conversion_sequencer
//
// Purpose:
//   Walks one conversion instruction across a whole vector register group.
//   For each source word it reads the register file, hands the word to the
//   conversion unit and writes back one result word (narrow / same width) or
//   two result words (widening: vd then vd_high). A one-cycle done pulse
//   marks completion.
//
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-high reset
//   bus    - vector_conversion_sequencer_if.slave (request handshake,
//            register file read/write ports, conversion unit ports, done)
//
// Optional feature:
//   Define CONVERSION_SEQUENCER_PERF_COUNTER_EN to add bus.busy_cycles, a
//   saturating 32-bit count of cycles spent outside IDLE.
//
// Addresses are flat word addresses {register, word} and wrap modulo the
// register file size; MAX_WORDS must equal 2**WORD_INDEX_WIDTH.
// ---------------------------------------------------------------------------
module vector_conversion_sequencer #(
    parameter int MAX_WORDS             = 8,
    parameter int WORD_INDEX_WIDTH      = 3,
    parameter int REGISTER_INDEX_WIDTH  = 5,
    parameter int CONVERSION_MODE_WIDTH = 4
) (
    input logic                         clock,
    input logic                         reset,
    vector_conversion_sequencer_if.slave bus
);
    localparam int CW = WORD_INDEX_WIDTH + 1;
    localparam int AW = REGISTER_INDEX_WIDTH + WORD_INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CONVERT,
        WRITE_LOW,
        WRITE_HIGH,
        DONE
    } state_t;

    state_t                           state_q;
    logic [WORD_INDEX_WIDTH-1:0]      wordIndex_q;
    logic [CW-1:0]                    lastIndex_q;
    logic                             widening_q;
    logic [REGISTER_INDEX_WIDTH-1:0]  vs2Base_q;
    logic [REGISTER_INDEX_WIDTH-1:0]  vdBase_q;
    logic [CONVERSION_MODE_WIDTH-1:0] cuMode_q;
    logic                             cuSign_q;
    logic [63:0]                      cuVs2_q;
    logic                             ready_q;
    logic                             readEn_q;
    logic [AW-1:0]                    readAddr_q;
    logic                             writeEn_q;
    logic                             writeHigh_q;
    logic [AW-1:0]                    writeAddr_q;
    logic                             done_q;

    logic [CW-1:0]                    clampedCount;
    logic [CW-1:0]                    countMinusOne;
    logic [WORD_INDEX_WIDTH-1:0]      nextIndex;
    logic [AW-1:0]                    firstReadAddr;
    logic [AW-1:0]                    nextReadAddr;
    logic [AW-1:0]                    narrowWriteAddr;
    logic [AW-1:0]                    wideLowAddr;
    logic [AW-1:0]                    wideHighAddr;

    // Oversized word counts are clamped to a full register group; the last
    // source index is kept one bit wider so it can be compared directly.
    // Address arithmetic is plain AW-bit addition, so running past the last
    // register simply wraps to word 0.
    assign clampedCount    = (bus.request_word_count > CW'(MAX_WORDS)) ? CW'(MAX_WORDS)
                                                                       : bus.request_word_count;
    assign countMinusOne   = clampedCount - CW'(1);
    assign nextIndex       = wordIndex_q + WORD_INDEX_WIDTH'(1);
    assign firstReadAddr   = {bus.request_vs2_base, {WORD_INDEX_WIDTH{1'b0}}};
    assign nextReadAddr    = {vs2Base_q, nextIndex};
    assign narrowWriteAddr = {vdBase_q, wordIndex_q};
    assign wideLowAddr     = {vdBase_q, {WORD_INDEX_WIDTH{1'b0}}} + AW'({wordIndex_q, 1'b0});
    assign wideHighAddr    = wideLowAddr + AW'(1);

    // Main sequencer FSM. Every strobe and address is registered on the edge
    // that enters the state using it, so the outputs are glitch-free and
    // line up with the state they belong to. The operand register is loaded
    // at the end of CONVERT, which is the cycle the register file returns data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wordIndex_q <= '0;
            lastIndex_q <= '0;
            widening_q  <= 1'b0;
            vs2Base_q   <= '0;
            vdBase_q    <= '0;
            cuMode_q    <= '0;
            cuSign_q    <= 1'b0;
            cuVs2_q     <= '0;
            ready_q     <= 1'b1;
            readEn_q    <= 1'b0;
            readAddr_q  <= '0;
            writeEn_q   <= 1'b0;
            writeHigh_q <= 1'b0;
            writeAddr_q <= '0;
            done_q      <= 1'b0;
        end else begin
            readEn_q    <= 1'b0;
            readAddr_q  <= '0;
            writeEn_q   <= 1'b0;
            writeHigh_q <= 1'b0;
            writeAddr_q <= '0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.request_valid && ready_q) begin
                        ready_q     <= 1'b0;
                        cuMode_q    <= bus.request_conversion_mode;
                        cuSign_q    <= bus.request_sign_mode;
                        widening_q  <= bus.request_widening;
                        vs2Base_q   <= bus.request_vs2_base;
                        vdBase_q    <= bus.request_vd_base;
                        lastIndex_q <= countMinusOne;
                        wordIndex_q <= '0;
                        if (clampedCount == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= READ;
                            readEn_q   <= 1'b1;
                            readAddr_q <= firstReadAddr;
                        end
                    end
                end
                READ: begin
                    state_q <= CONVERT;
                end
                CONVERT: begin
                    cuVs2_q     <= bus.rf_read_data;
                    state_q     <= WRITE_LOW;
                    writeEn_q   <= 1'b1;
                    writeAddr_q <= widening_q ? wideLowAddr : narrowWriteAddr;
                end
                WRITE_LOW: begin
                    if (widening_q) begin
                        state_q     <= WRITE_HIGH;
                        writeEn_q   <= 1'b1;
                        writeHigh_q <= 1'b1;
                        writeAddr_q <= wideHighAddr;
                    end else if ({1'b0, wordIndex_q} == lastIndex_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        wordIndex_q <= nextIndex;
                        state_q     <= READ;
                        readEn_q    <= 1'b1;
                        readAddr_q  <= nextReadAddr;
                    end
                end
                WRITE_HIGH: begin
                    if ({1'b0, wordIndex_q} == lastIndex_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        wordIndex_q <= nextIndex;
                        state_q     <= READ;
                        readEn_q    <= 1'b1;
                        readAddr_q  <= nextReadAddr;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Write data has to follow the conversion unit combinationally because
    // the unit's operand only settles on the edge that enters WRITE_LOW.
    assign bus.rf_write_data      = writeEn_q ? (writeHigh_q ? bus.cu_vd_high : bus.cu_vd) : 64'd0;
    assign bus.request_ready      = ready_q;
    assign bus.rf_read_enable     = readEn_q;
    assign bus.rf_read_address    = readAddr_q;
    assign bus.cu_conversion_mode = cuMode_q;
    assign bus.cu_sign_mode       = cuSign_q;
    assign bus.cu_vs2             = cuVs2_q;
    assign bus.rf_write_enable    = writeEn_q;
    assign bus.rf_write_address   = writeAddr_q;
    assign bus.done               = done_q;

`ifdef CONVERSION_SEQUENCER_PERF_COUNTER_EN
    logic [31:0] busyCycles_q;

    // Counts every cycle spent outside IDLE (DONE included) and sticks at
    // all-ones instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busyCycles_q <= '0;
        end else if ((state_q != IDLE) && (busyCycles_q != 32'hFFFF_FFFF)) begin
            busyCycles_q <= busyCycles_q + 32'd1;
        end
    end

    assign bus.busy_cycles = busyCycles_q;
`endif

endmodule

// File: tb/tb_vector_conversion_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_conversion_sequencer
//
// Drives vector_conversion_sequencer with a table of directed instructions,
// models the register file (address-derived read data, one cycle latency)
// and the conversion unit (half swap xor mode for vd, inversion for vd_high),
// records every read/write strobe and compares against hand-computed values.
// Hand-written sequences cover reset in the middle of an instruction and,
// with CONVERSION_SEQUENCER_PERF_COUNTER_EN, the busy cycle counter.
// ---------------------------------------------------------------------------
module tb_vector_conversion_sequencer;

    typedef struct {
        logic [3:0] mode;
        logic       sign;
        logic       widening;
        logic [3:0] count;
        logic [4:0] vs2;
        logic [4:0] vd;
        int         expReads;
        int         expWrites;
        int         expDone;
        int         expFirstRead;
        int         expFirstWrite;
        int         expLastWrite;
    } vec_t;

    logic clock = 1'b0;
    logic reset;

    vector_conversion_sequencer_if bus();

    vector_conversion_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int totalChecks  = 0;
    int passedChecks = 0;

    logic [7:0]  readQ[$];
    logic [7:0]  writeAddrQ[$];
    logic [63:0] writeDataQ[$];
    int          doneCycle;
    int          collisions;
    int          readyWhileBusy;
    logic        readyAfter;
    logic [3:0]  modeAfter;
    logic        signAfter;

    vec_t vectors[7];

    // Register file read data is derived from the address so every word is unique.
    function automatic logic [63:0] pat(input logic [7:0] a);
        return {24'hC0FFEE, a, 24'h5A17C3, ~a};
    endfunction

    // Conversion unit stand-in for the low result; depends on the mode so the
    // latched mode is visible in the written data.
    function automatic logic [63:0] cuLow(input logic [63:0] x, input logic [3:0] m);
        return {x[31:0], x[63:32]} ^ {60'd0, m};
    endfunction

    // Register file read port: data appears the cycle after the strobe,
    // otherwise a poison value.
    always @(posedge clock) begin
        bus.rf_read_data <= bus.rf_read_enable ? pat(bus.rf_read_address) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // Combinational conversion unit.
    assign bus.cu_vd      = cuLow(bus.cu_vs2, bus.cu_conversion_mode);
    assign bus.cu_vd_high = ~bus.cu_vs2;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ready"},    64'(bus.request_ready), 64'd1);
        checkOutput({tag, "_rd_en"},    64'(bus.rf_read_enable), 64'd0);
        checkOutput({tag, "_rd_addr"},  64'(bus.rf_read_address), 64'd0);
        checkOutput({tag, "_wr_en"},    64'(bus.rf_write_enable), 64'd0);
        checkOutput({tag, "_wr_addr"},  64'(bus.rf_write_address), 64'd0);
        checkOutput({tag, "_wr_data"},  bus.rf_write_data, 64'd0);
        checkOutput({tag, "_cu_vs2"},   bus.cu_vs2, 64'd0);
        checkOutput({tag, "_cu_mode"},  64'(bus.cu_conversion_mode), 64'd0);
        checkOutput({tag, "_cu_sign"},  64'(bus.cu_sign_mode), 64'd0);
        checkOutput({tag, "_done"},     64'(bus.done), 64'd0);
    endtask

    // Issues one instruction, holds request_valid while the sequencer is busy
    // and records every strobe until done or a 60-cycle budget runs out.
    // Cycle 1 is the cycle right after the accepting edge.
    task automatic applyStimulus(input vec_t v);
        readQ.delete();
        writeAddrQ.delete();
        writeDataQ.delete();
        doneCycle      = -1;
        collisions     = 0;
        readyWhileBusy = 0;
        @(negedge clock);
        bus.request_valid           = 1'b1;
        bus.request_conversion_mode = v.mode;
        bus.request_sign_mode       = v.sign;
        bus.request_widening        = v.widening;
        bus.request_word_count      = v.count;
        bus.request_vs2_base        = v.vs2;
        bus.request_vd_base         = v.vd;
        @(posedge clock);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clock);
            if (bus.rf_read_enable && bus.rf_write_enable) collisions++;
            if (bus.rf_read_enable) readQ.push_back(bus.rf_read_address);
            if (bus.rf_write_enable) begin
                writeAddrQ.push_back(bus.rf_write_address);
                writeDataQ.push_back(bus.rf_write_data);
            end
            if (bus.request_ready) readyWhileBusy++;
            if (bus.done) begin
                doneCycle = cyc;
                break;
            end
        end
        bus.request_valid = 1'b0;
        @(negedge clock);
        readyAfter = bus.request_ready;
        modeAfter  = bus.cu_conversion_mode;
        signAfter  = bus.cu_sign_mode;
    endtask

    task automatic checkTxn(input string tag, input vec_t v);
        checkOutput({tag, "_reads"},      64'(readQ.size()), 64'(v.expReads));
        checkOutput({tag, "_writes"},     64'(writeAddrQ.size()), 64'(v.expWrites));
        checkOutput({tag, "_done_cycle"}, 64'(doneCycle), 64'(v.expDone));
        checkOutput({tag, "_ready_busy"}, 64'(readyWhileBusy), 64'd0);
        checkOutput({tag, "_ready_back"}, 64'(readyAfter), 64'd1);
        checkOutput({tag, "_rw_overlap"}, 64'(collisions), 64'd0);
        checkOutput({tag, "_cu_mode"},    64'(modeAfter), 64'(v.mode));
        checkOutput({tag, "_cu_sign"},    64'(signAfter), 64'(v.sign));
        if (readQ.size() > 0 && v.expReads > 0)
            checkOutput({tag, "_first_read"}, 64'(readQ[0]), 64'(v.expFirstRead));
        if (writeAddrQ.size() > 0 && v.expWrites > 0) begin
            checkOutput({tag, "_first_write"}, 64'(writeAddrQ[0]), 64'(v.expFirstWrite));
            checkOutput({tag, "_last_write"},  64'(writeAddrQ[writeAddrQ.size()-1]), 64'(v.expLastWrite));
        end
        for (int k = 0; k < v.expReads; k++) begin
            int ra;
            int wa;
            ra = (int'(v.vs2) * 8 + k) % 256;
            if (k < readQ.size())
                checkOutput($sformatf("%s_rd%0d_addr", tag, k), 64'(readQ[k]), 64'(ra));
            if (v.widening) begin
                wa = (int'(v.vd) * 8 + 2 * k) % 256;
                if (2 * k + 1 < writeAddrQ.size()) begin
                    checkOutput($sformatf("%s_wrlo%0d_addr", tag, k), 64'(writeAddrQ[2*k]), 64'(wa));
                    checkOutput($sformatf("%s_wrlo%0d_data", tag, k), writeDataQ[2*k], cuLow(pat(8'(ra)), v.mode));
                    checkOutput($sformatf("%s_wrhi%0d_addr", tag, k), 64'(writeAddrQ[2*k+1]), 64'(wa + 1));
                    checkOutput($sformatf("%s_wrhi%0d_data", tag, k), writeDataQ[2*k+1], ~pat(8'(ra)));
                end
            end else begin
                wa = (int'(v.vd) * 8 + k) % 256;
                if (k < writeAddrQ.size()) begin
                    checkOutput($sformatf("%s_wr%0d_addr", tag, k), 64'(writeAddrQ[k]), 64'(wa));
                    checkOutput($sformatf("%s_wr%0d_data", tag, k), writeDataQ[k], cuLow(pat(8'(ra)), v.mode));
                end
            end
        end
    endtask

    initial begin
        int strobes;
        int dones;

        //                mode   sign  wide  count  vs2    vd     rd wr done fRd fWr lWr
        vectors[0] = '{4'd3,  1'b1, 1'b0, 4'd2,  5'd3,  5'd5,  2, 2,  7,  24, 40, 41};
        vectors[1] = '{4'd5,  1'b0, 1'b1, 4'd2,  5'd1,  5'd6,  2, 4,  9,   8, 48, 51};
        vectors[2] = '{4'd2,  1'b1, 1'b0, 4'd0,  5'd4,  5'd4,  0, 0,  1,   0,  0,  0};
        vectors[3] = '{4'd9,  1'b0, 1'b0, 4'd12, 5'd2,  5'd10, 8, 8, 25,  16, 80, 87};
        vectors[4] = '{4'd12, 1'b1, 1'b1, 4'd8,  5'd31, 5'd31, 8, 16, 33, 248, 248, 7};
        vectors[5] = '{4'd15, 1'b0, 1'b0, 4'd8,  5'd0,  5'd31, 8, 8, 25,   0, 248, 255};
        vectors[6] = '{4'd6,  1'b1, 1'b1, 4'd1,  5'd7,  5'd0,  1, 2,  5,  56,  0,  1};

        reset                       = 1'b1;
        bus.request_valid           = 1'b0;
        bus.request_conversion_mode = '0;
        bus.request_sign_mode       = 1'b0;
        bus.request_widening        = 1'b0;
        bus.request_word_count      = '0;
        bus.request_vs2_base        = '0;
        bus.request_vd_base         = '0;

        repeat (2) @(negedge clock);
        checkIdleOutputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vectors[i]);
            checkTxn($sformatf("v%0d", i), vectors[i]);
        end

        // Reset asserted during the second WRITE_LOW of a narrow count=2 instruction.
        @(negedge clock);
        bus.request_valid           = 1'b1;
        bus.request_conversion_mode = 4'd3;
        bus.request_sign_mode       = 1'b1;
        bus.request_widening        = 1'b0;
        bus.request_word_count      = 4'd2;
        bus.request_vs2_base        = 5'd3;
        bus.request_vd_base         = 5'd5;
        @(posedge clock);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clock);
            if (cyc == 1) bus.request_valid = 1'b0;
        end
        checkOutput("midrst_pre_wr_en",   64'(bus.rf_write_enable), 64'd1);
        checkOutput("midrst_pre_wr_addr", 64'(bus.rf_write_address), 64'd41);
        reset = 1'b1;
        #1;
        checkIdleOutputs("midrst");
        @(negedge clock);
        reset   = 1'b0;
        strobes = 0;
        dones   = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clock);
            if (bus.done) dones++;
            if (bus.rf_read_enable || bus.rf_write_enable) strobes++;
        end
        checkOutput("midrst_no_done",    64'(dones), 64'd0);
        checkOutput("midrst_no_strobes", 64'(strobes), 64'd0);
        applyStimulus(vectors[0]);
        checkTxn("after_rst", vectors[0]);

`ifdef CONVERSION_SEQUENCER_PERF_COUNTER_EN
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("busy_reset", 64'(bus.busy_cycles), 64'd0);
        applyStimulus(vectors[6]);
        checkOutput("busy_wide1", 64'(bus.busy_cycles), 64'd5);
        force dut.busyCycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.busyCycles_q;
        applyStimulus(vectors[6]);
        checkOutput("busy_saturate", 64'(bus.busy_cycles), 64'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule

// File: doc/vector_conversion_sequencer.md
Name: vector_conversion_sequencer

Overview:
Multi-cycle controller that drives the vector conversion unit across a whole register group. It accepts one conversion instruction from issue over a valid/ready handshake and reads source words from the vector register file one at a time. It presents each word to the conversion unit, then writes the result back: one word for narrow/same-width modes, two words (vd, vd_high) for widening modes. It sits between vector issue, the vector register file ports and the vector_conversion_unit.

Parameters:
MAX_WORDS, 8, 64-bit words per vector register
WORD_INDEX_WIDTH, 3, log2(MAX_WORDS)
REGISTER_INDEX_WIDTH, 5, vector register index width
CONVERSION_MODE_WIDTH, 4, width of the conversion_mode field

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
request_valid  input  1  instruction available
request_ready  output  1  sequencer can accept an instruction
request_conversion_mode  input  CONVERSION_MODE_WIDTH  conversion mode
request_sign_mode  input  1  1 = signed
request_widening  input  1  1 = mode produces vd and vd_high
request_word_count  input  WORD_INDEX_WIDTH+1  source words to process
request_vs2_base  input  REGISTER_INDEX_WIDTH  source register
request_vd_base  input  REGISTER_INDEX_WIDTH  destination register
rf_read_enable  output  1  register file read strobe
rf_read_address  output  REGISTER_INDEX_WIDTH+WORD_INDEX_WIDTH  flat word address
rf_read_data  input  64  read data, valid the cycle after rf_read_enable
cu_conversion_mode  output  CONVERSION_MODE_WIDTH  to conversion unit
cu_sign_mode  output  1  to conversion unit
cu_vs2  output  64  operand register to conversion unit
cu_vd  input  64  conversion unit result (combinational)
cu_vd_high  input  64  conversion unit upper result (combinational)
rf_write_enable  output  1  register file write strobe
rf_write_address  output  REGISTER_INDEX_WIDTH+WORD_INDEX_WIDTH  flat word address
rf_write_data  output  64  write data
done  output  1  one-cycle pulse when the instruction completes

Behaviour:
- Reset (async, active-high): state IDLE.
  - request_ready=1.
  - All other outputs 0, including cu_vs2, cu_conversion_mode, cu_sign_mode and the internal counters.
  - Reset mid-instruction abandons the instruction. Writes already performed are not undone. No done pulse is produced.
- Handshake:
  - request_ready=1 only in IDLE.
  - Accept on the rising edge where request_valid & request_ready.
  - On accept, latch mode, sign, widening, bases and word count.
  - cu_conversion_mode and cu_sign_mode are registered. They hold the latched values until the next accept.
- Word count: a count greater than MAX_WORDS is clamped to MAX_WORDS. A count of 0 goes IDLE -> DONE with no reads or writes.
- Source index i runs from 0 to count-1.
- Addresses:
  - read address = vs2_base*MAX_WORDS + i
  - narrow write address = vd_base*MAX_WORDS + i
  - widening write addresses = vd_base*MAX_WORDS + 2i, then +2i+1
  - All addresses are computed modulo 2^(REGISTER_INDEX_WIDTH+WORD_INDEX_WIDTH), so they wrap past the last register to word 0.
- FSM:
  - IDLE: on accept -> READ, or -> DONE if count=0.
  - READ: rf_read_enable=1, rf_read_address=read address(i). -> CONVERT.
  - CONVERT: cu_vs2 <= rf_read_data at the end of the cycle. -> WRITE_LOW.
  - WRITE_LOW: rf_write_enable=1, data=cu_vd, address=low write address. Then:
    - widening -> WRITE_HIGH;
    - else if i=count-1 -> DONE;
    - else i++ and -> READ.
  - WRITE_HIGH: rf_write_enable=1, data=cu_vd_high, address=vd_base*MAX_WORDS+2i+1. If i=count-1 -> DONE, else i++ and -> READ.
  - DONE: done=1 for one cycle. -> IDLE.
- Throughput: narrow 3 cycles per word, widening 4 cycles per word, plus 1 DONE cycle.
- rf_read_enable and rf_write_enable are never high in the same cycle.
- cu_vs2 is stable from CONVERT+1 through the last write of that word.
- request_valid while busy is ignored (ready=0). The requester must hold it.

Optional Feature:
Macro CONVERSION_SEQUENCER_PERF_COUNTER_EN.
- Defined: adds output busy_cycles (32 bits), reset to 0.
- busy_cycles increments on every cycle the state is not IDLE and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Narrow: count=2, vs2_base=3, vd_base=5. Expect reads at 24,25 and writes at 40,41 with data = cu_vd. done at cycle 7 after accept, ready back at cycle 8.
- Widening: count=2, vs2_base=1, vd_base=6. Expect reads at 8,9 and writes at 48(vd),49(vd_high),50,51. done at cycle 9.
- count=0 -> no rf strobes; done on the first cycle after accept. Count=12 -> clamped to 8 reads, 8 writes.
- Wrap: vs2_base=31, vd_base=31, widening, count=8. Expect reads 248..255 and writes 248..255 then 0..7.
- Assert reset during the second WRITE_LOW. Expect all outputs 0 and ready=1 immediately, no done pulse, and a new request accepted normally.
- With the macro defined: widening count=1 -> busy_cycles=5 afterwards. Force the counter to 0xFFFFFFFE, run 3 busy cycles -> value holds at 0xFFFFFFFF.
